// File: rtl/ibus_cache.sv
// rtl/ibus_cache.sv - direct-mapped 4-word-line instruction cache on the fetch bus; optional counters under IBUS_CACHE_STATS_EN
module ibus_cache #(
    parameter int LOG2LINES = 6,
    parameter int LINES     = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] bus_address,
    input  logic        bus_en,
    input  logic        bus_squashn,
    output logic [31:0] bus_readdata,
    output logic        bus_wait,
    output logic [31:0] bus_ecause,
    input  logic        invalidate,
    output logic [31:0] mem_address,
    output logic        mem_en,
    input  logic [31:0] mem_readdata,
    input  logic        mem_valid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAGW = 32 - LOG2LINES - 4;

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_REFILL = 2'd1,
        ST_INVAL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          req_addr_q, req_addr_d;
    logic                 req_valid_q, req_valid_d;
    logic [31:0]          refill_base_q, refill_base_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [LOG2LINES-1:0] icnt_q, icnt_d;
    logic                 inval_pend_q, inval_pend_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic                 mem_en_q, mem_en_d;
    logic [31:0]          mem_address_q, mem_address_d;

    logic [31:0]          data_mem [LINES*4];
    logic [TAGW-1:0]      tag_mem  [LINES];

    logic [LOG2LINES-1:0] req_idx;
    logic [LOG2LINES-1:0] fill_idx;
    logic [TAGW-1:0]      req_tag;
    logic                 aligned;
    logic                 hit;
    logic                 miss;
    logic                 fill_we;
    logic                 fill_last;

    assign req_idx  = req_addr_q[LOG2LINES+3:4];
    assign req_tag  = req_addr_q[31:LOG2LINES+4];
    // The line being filled comes from refill_base, since a squash may move req_addr mid-refill
    assign fill_idx = refill_base_q[LOG2LINES+3:4];

    assign aligned  = (req_addr_q[1:0] == 2'b00);
    assign hit      = req_valid_q & aligned & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);
    assign miss     = req_valid_q & aligned & ~hit;

    assign bus_wait     = (state_q != ST_READY) | miss;
    assign bus_readdata = hit ? data_mem[{req_idx, req_addr_q[3:2]}] : 32'd0;
    assign bus_ecause   = (req_valid_q & ~aligned) ? 32'h0000_0010 : 32'd0;
    assign mem_en       = mem_en_q;
    assign mem_address  = mem_address_q;

    // Next-state logic for request capture, refill sequencing and the invalidate sweep
    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        req_valid_d   = req_valid_q;
        refill_base_d = refill_base_q;
        cnt_d         = cnt_q;
        icnt_d        = icnt_q;
        inval_pend_d  = inval_pend_q;
        valid_d       = valid_q;
        fill_we       = 1'b0;
        fill_last     = 1'b0;

        case (state_q)
            ST_READY: begin
                if (bus_en) begin
                    req_addr_d  = bus_address;
                    req_valid_d = 1'b1;
                end
                if (invalidate) begin
                    state_d = ST_INVAL;
                    icnt_d  = '0;
                end else if (miss) begin
                    state_d       = ST_REFILL;
                    refill_base_d = {req_addr_q[31:4], 4'b0000};
                    cnt_d         = 2'd0;
                end
            end
            ST_REFILL: begin
                if (bus_en && !bus_squashn) begin
                    req_addr_d = bus_address;
                end
                if (invalidate) begin
                    inval_pend_d = 1'b1;
                end
                if (mem_valid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        fill_last         = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        if (inval_pend_q || invalidate) begin
                            state_d      = ST_INVAL;
                            icnt_d       = '0;
                            inval_pend_d = 1'b0;
                        end else begin
                            state_d = ST_READY;
                        end
                    end
                end
            end
            ST_INVAL: begin
                valid_d[icnt_q] = 1'b0;
                icnt_d          = icnt_q + 1'b1;
                if (icnt_q == LOG2LINES'(LINES - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        mem_en_d      = (state_d == ST_REFILL);
        mem_address_d = mem_en_d ? (refill_base_d + {28'd0, cnt_d, 2'b00}) : 32'd0;
    end

    // Controller state and registered memory-side outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_READY;
            req_addr_q    <= 32'd0;
            req_valid_q   <= 1'b0;
            refill_base_q <= 32'd0;
            cnt_q         <= 2'd0;
            icnt_q        <= '0;
            inval_pend_q  <= 1'b0;
            valid_q       <= '0;
            mem_en_q      <= 1'b0;
            mem_address_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            req_valid_q   <= req_valid_d;
            refill_base_q <= refill_base_d;
            cnt_q         <= cnt_d;
            icnt_q        <= icnt_d;
            inval_pend_q  <= inval_pend_d;
            valid_q       <= valid_d;
            mem_en_q      <= mem_en_d;
            mem_address_q <= mem_address_d;
        end
    end

    // Refill beats land in the data array; the tag is written with the last beat
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{fill_idx, cnt_q}] <= mem_readdata;
        end
        if (fill_last) begin
            tag_mem[fill_idx] <= refill_base_q[31:LOG2LINES+4];
        end
    end

`ifdef IBUS_CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // A hit is counted when the fetch unit consumes it with a new capture; a miss when a refill starts
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if ((state_q == ST_READY) && hit && bus_en) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == ST_READY) && (state_d == ST_REFILL)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
